// File: rtl/inv_shift_rows_buf.sv
// Column-serial AES InvShiftRows stage: scatters incoming columns into a ping-pong pair of
// 128-bit banks and streams inverse-shifted columns out. Optional feature macro: ISR_BYPASS_EN.
module inv_shift_rows_buf #(
  parameter bit CLR_ON_READ = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_col,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_col,
  output logic        out_last,
  output logic        busy
`ifdef ISR_BYPASS_EN
  ,
  input  logic        bypass
`endif
);

  logic [127:0] bank [2];
  logic [1:0]   full;
  logic [1:0]   full_nxt;
  logic         wr_bank;
  logic         rd_bank;
  logic [1:0]   wr_col;
  logic [1:0]   rd_col;
  logic         wr_fire;
  logic         rd_fire;
  logic         blk_done;
  logic         rd_done;
  logic         blk_byp;
  logic [127:0] wr_mask;
  logic [127:0] wr_data;

  assign in_ready  = !full[wr_bank];
  assign out_valid = full[rd_bank];
  assign out_last  = out_valid && (rd_col == 2'd3);
  assign out_col   = bank[rd_bank][32*(3-int'(rd_col)) +: 32];
  assign busy      = (|full) || (wr_col != 2'd0);

  assign wr_fire  = in_valid && in_ready;
  assign rd_fire  = out_valid && out_ready;
  assign blk_done = wr_fire && (wr_col == 2'd3);
  assign rd_done  = rd_fire && (rd_col == 2'd3);

`ifdef ISR_BYPASS_EN
  logic [1:0] byp;
  // The first column carries the block's bypass flag; later columns reuse the stored copy.
  assign blk_byp = (wr_col == 2'd0) ? bypass : byp[wr_bank];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                       byp <= '0;
    else if (flush)                     byp <= '0;
    else if (wr_fire && wr_col == 2'd0) byp[wr_bank] <= bypass;
  end
`else
  assign blk_byp = 1'b0;
`endif

  // Byte r lands in column wr_col+r (mod 4) so row r ends up rotated right by r.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wr_mask = '0;
    wr_data = '0;
    for (int r = 0; r < 4; r++) begin
      int dst;
      int idx;
      dst = blk_byp ? int'(wr_col) : (int'(wr_col) + r) % 4;
      idx = 127 - 32*dst - 8*r;
      wr_mask[idx -: 8] = 8'hff;
      wr_data[idx -: 8] = in_col[31-8*r -: 8];
    end
  end

  always_comb begin
    full_nxt = full;
    if (rd_done)  full_nxt[rd_bank] = 1'b0;
    if (blk_done) full_nxt[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) begin
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_col  <= '0;
      rd_col  <= '0;
    end else if (flush) begin
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_col  <= '0;
      rd_col  <= '0;
    end else begin
      full <= full_nxt;
      if (wr_fire) begin
        wr_col <= wr_col + 2'd1;
        if (blk_done) wr_bank <= ~wr_bank;
      end
      if (rd_fire) begin
        rd_col <= rd_col + 2'd1;
        if (rd_done) rd_bank <= ~rd_bank;
      end
    end
  end

  // A block being written and a block being drained never share a bank, so the two updates
  // below are mutually exclusive per bank.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: the banks are reset because out_col is read straight from them and must be 0 out of reset.
    if (!reset_n) begin
      for (int b = 0; b < 2; b++) bank[b] <= '0;
    end else if (flush) begin
      if (CLR_ON_READ) begin
        for (int b = 0; b < 2; b++) bank[b] <= '0;
      end
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (wr_fire && wr_bank == 1'(b))
          bank[b] <= (bank[b] & ~wr_mask) | (wr_data & wr_mask);
        else if (CLR_ON_READ && rd_done && rd_bank == 1'(b))
          bank[b] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_inv_shift_rows_buf.sv
// Self-checking bench for inv_shift_rows_buf: table vectors, hand-written corner sequences and a
// randomized run checked by a block-level reference model. Honours ISR_BYPASS_EN when defined.
module tb_inv_shift_rows_buf;

`ifdef ISR_BYPASS_EN
  localparam bit HAS_BYP = 1'b1;
`else
  localparam bit HAS_BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_col = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_col;
  logic        out_last;
  logic        busy;
  logic        bypass = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  inv_shift_rows_buf dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_col    (in_col),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_col   (out_col),
    .out_last  (out_last),
    .busy      (busy)
`ifdef ISR_BYPASS_EN
    ,
    .bypass    (bypass)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Output column c, row r is input column (c-r) mod 4, row r; bypassed blocks are unshifted.
  function automatic logic [31:0] ref_col(input logic [127:0] blk, input bit byp, input int c);
    logic [31:0] res;
    res = '0;
    for (int r = 0; r < 4; r++) begin
      int src;
      src = byp ? c : (c - r + 4) % 4;
      res[31-8*r -: 8] = blk[127-32*src-8*r -: 8];
    end
    return res;
  endfunction

  // Block-level reference model, evaluated on the falling edge before each handshake edge.
  bit           mon_en = 1'b0;
  logic [127:0] cur_blk;
  int           cur_n = 0;
  bit           cur_byp = 1'b0;
  logic [31:0]  exp_q[$];
  int           n_full = 0;
  int           rd_idx = 0;

  function automatic void reset_model();
    cur_n  = 0;
    n_full = 0;
    rd_idx = 0;
    exp_q.delete();
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (flush) begin
        reset_model();
      end else begin
        check("mon_in_ready", 32'(in_ready), 32'(n_full < 2));
        check("mon_out_valid", 32'(out_valid), 32'(n_full > 0));
        check("mon_busy", 32'(busy), 32'(n_full > 0 || cur_n != 0));
        if (out_valid && out_ready && exp_q.size() > 0) begin
          logic [31:0] e;
          e = exp_q.pop_front();
          check("mon_out_col", out_col, e);
          check("mon_out_last", 32'(out_last), 32'(rd_idx == 3));
          rd_idx = (rd_idx + 1) % 4;
          if (rd_idx == 0) n_full--;
        end
        if (in_valid && in_ready) begin
          if (cur_n == 0) cur_byp = HAS_BYP && bypass;
          cur_blk[127-32*cur_n -: 32] = in_col;
          cur_n++;
          if (cur_n == 4) begin
            for (int c = 0; c < 4; c++) exp_q.push_back(ref_col(cur_blk, cur_byp, c));
            n_full++;
            cur_n = 0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_col(input logic [31:0] c, input bit b);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_col   = c;
    bypass   = b;
    for (int k = 0; k < 50; k++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) check("in_ready_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic get_col(output logic [31:0] c, output logic l);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) check("out_valid_timeout", 32'(out_valid), 32'd1);
    c = out_col;
    l = out_last;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic run_block(input logic [127:0] din, input logic [127:0] dexp, input bit b,
                           input string tag);
    logic [31:0] c;
    logic        l;
    for (int i = 0; i < 4; i++) put_col(din[127-32*i -: 32], b);
    check({tag, "_latency"}, 32'(out_valid), 32'd1);
    for (int i = 0; i < 4; i++) begin
      get_col(c, l);
      check($sformatf("%s_col%0d", tag, i), c, dexp[127-32*i -: 32]);
      check($sformatf("%s_last%0d", tag, i), 32'(l), 32'(i == 3));
    end
  endtask

  typedef struct packed {
    logic [127:0] din;
    logic [127:0] dexp;
  } vec_t;

  vec_t tbl[3];

  initial begin
    tbl[0] = '{din:  128'h00010203_04050607_08090a0b_0c0d0e0f,
               dexp: 128'h000d0a07_04010e0b_0805020f_0c090603};
    tbl[1] = '{din:  128'h11223344_55667788_99aabbcc_ddeeff00,
               dexp: 128'h11eebb88_5522ffcc_99663300_ddaa7744};
    tbl[2] = '{din:  128'h00ff00ff_00000000_00000000_00000000,
               dexp: 128'h00000000_00ff0000_00000000_000000ff};

    // Reset state
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_col", out_col, 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    tick();
    mon_en = 1'b1;

    // Table vectors, one block at a time
    for (int v = 0; v < 3; v++) run_block(tbl[v].din, tbl[v].dexp, 1'b0, $sformatf("tbl%0d", v));

    // Two blocks with downstream stalled, then drain
    begin
      logic [255:0] both_exp;
      both_exp = {tbl[0].dexp, tbl[1].dexp};
      for (int i = 0; i < 4; i++) put_col(tbl[0].din[127-32*i -: 32], 1'b0);
      for (int i = 0; i < 4; i++) put_col(tbl[1].din[127-32*i -: 32], 1'b0);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_busy", 32'(busy), 32'd1);
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
        check($sformatf("stall_col%0d", i), out_col, both_exp[255-32*i -: 32]);
        if (i == 3) check("stall_ready_before_drain", 32'(in_ready), 32'd0);
        tick();
        if (i == 3) check("stall_ready_after_drain", 32'(in_ready), 32'd1);
      end
      out_ready = 1'b0;
      check("stall_empty", 32'(out_valid), 32'd0);
    end

    // Continuous stream of three blocks
    begin
      logic [127:0] blk[3];
      for (int b = 0; b < 3; b++) blk[b] = {$urandom, $urandom, $urandom, $urandom};
      out_ready = 1'b1;
      for (int t = 0; t < 17; t++) begin
        in_valid = (t < 12);
        in_col   = (t < 12) ? blk[t/4][127-32*(t%4) -: 32] : 32'd0;
        if (t < 12) check($sformatf("stream_in_ready%0d", t), 32'(in_ready), 32'd1);
        if (t >= 4 && t < 16) begin
          check($sformatf("stream_valid%0d", t), 32'(out_valid), 32'd1);
          check($sformatf("stream_col%0d", t), out_col, ref_col(blk[(t-4)/4], 1'b0, (t-4)%4));
        end else begin
          check($sformatf("stream_idle%0d", t), 32'(out_valid), 32'd0);
        end
        tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
    end

    // Flush a partial block, then confirm no stale bytes leak out
    put_col(tbl[1].din[127 -: 32], 1'b0);
    put_col(tbl[1].din[95 -: 32], 1'b0);
    check("flush_busy_before", 32'(busy), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy_after", 32'(busy), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    run_block(tbl[0].din, tbl[0].dexp, 1'b0, "post_flush");

    // Asynchronous reset in the middle of a readout
    begin
      logic [31:0] c;
      logic        l;
      for (int i = 0; i < 4; i++) put_col(tbl[0].din[127-32*i -: 32], 1'b0);
      get_col(c, l);
      get_col(c, l);
      mon_en = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      check("arst_out_valid", 32'(out_valid), 32'd0);
      check("arst_in_ready", 32'(in_ready), 32'd1);
      check("arst_out_col", out_col, 32'd0);
      check("arst_out_last", 32'(out_last), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      #3 reset_n = 1'b1;
      tick();
      reset_model();
      mon_en = 1'b1;
      run_block(tbl[0].din, tbl[0].dexp, 1'b0, "post_arst");
    end

`ifdef ISR_BYPASS_EN
    run_block(tbl[0].din, tbl[0].din, 1'b1, "bypass_on");
    run_block(tbl[0].din, tbl[0].dexp, 1'b0, "bypass_off");
`endif

    // Randomized traffic with occasional flush, checked by the monitor model
    for (int t = 0; t < 3000; t++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_col    = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 99) == 0);
      bypass    = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (12) tick();
    check("final_drained", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
